// File: rtl/ripple_monitor.sv
// Sequence monitor for a free-running WIDTH-bit counter: acquires lock after a run of +1 steps,
// then flags breaks and wrap-arounds with saturating event counters.
module ripple_monitor #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned LOCK_LEN = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] count_in,
    input  logic             count_valid,
    input  logic             resync,
    output logic             locked,
    output logic             err,
    output logic             wrap,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] wrap_count
);

    typedef enum logic [1:0] {
        IDLE,
        ACQ,
        LOCK
    } state_e;

    localparam logic [3:0]       LOCK_RUN = 4'(LOCK_LEN);
    localparam logic [WIDTH-1:0] REF_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic [WIDTH-1:0] expected;
    logic [3:0]       run_q, run_d;
    logic [3:0]       run_inc;
    logic             match;
    logic             err_q, err_d;
    logic             wrap_q, wrap_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [CNT_W-1:0] wrap_count_q, wrap_count_d;

    always_comb begin
        state_d      = state_q;
        ref_d        = ref_q;
        run_d        = run_q;
        err_d        = 1'b0;
        wrap_d       = 1'b0;
        err_count_d  = err_count_q;
        wrap_count_d = wrap_count_q;
        expected     = ref_q + WIDTH'(1);
        run_inc      = run_q + 4'd1;
        match        = (count_in == expected);

        // resync wins over a sample arriving in the same cycle
        if (resync) begin
            state_d = IDLE;
            run_d   = '0;
        end else if (count_valid) begin
            ref_d = count_in;
            case (state_q)
                IDLE: begin
                    run_d   = '0;
                    state_d = ACQ;
                end
                ACQ: begin
                    if (match) begin
                        run_d = run_inc;
                        if (run_inc == LOCK_RUN) begin
                            state_d = LOCK;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                LOCK: begin
                    if (match) begin
                        if (ref_q == REF_MAX) begin
                            wrap_d = 1'b1;
                            if (wrap_count_q != CNT_MAX) begin
                                wrap_count_d = wrap_count_q + CNT_W'(1);
                            end
                        end
                    end else begin
                        err_d   = 1'b1;
                        run_d   = '0;
                        state_d = ACQ;
                        if (err_count_q != CNT_MAX) begin
                            err_count_d = err_count_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            ref_q        <= '0;
            run_q        <= '0;
            err_q        <= 1'b0;
            wrap_q       <= 1'b0;
            err_count_q  <= '0;
            wrap_count_q <= '0;
        end else begin
            state_q      <= state_d;
            ref_q        <= ref_d;
            run_q        <= run_d;
            err_q        <= err_d;
            wrap_q       <= wrap_d;
            err_count_q  <= err_count_d;
            wrap_count_q <= wrap_count_d;
        end
    end

    assign locked     = (state_q == LOCK);
    assign err        = err_q;
    assign wrap       = wrap_q;
    assign err_count  = err_count_q;
    assign wrap_count = wrap_count_q;

endmodule

// File: tb/tb_ripple_monitor.sv
// Drives two monitors (LOCK_LEN 4 and 1) with the same stream and compares them against a
// streak-length model of the sequence rules.
module tb_ripple_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       cv;
    logic       rs;
    logic [3:0] ci;
    logic       lk [2];
    logic       er [2];
    logic       wr [2];
    logic [7:0] ec [2];
    logic [7:0] wc [2];

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Model: streak = number of samples in the current unbroken +1 chain (0 = nothing seen)
    int m_streak [2];
    int m_last   [2];
    int m_ec     [2];
    int m_wc     [2];
    int m_err    [2];
    int m_wrap   [2];

    always #5 clk = ~clk;

    ripple_monitor #(.WIDTH(4), .LOCK_LEN(4), .CNT_W(8)) u_dut4 (
        .clk(clk), .Reset(rst), .count_in(ci), .count_valid(cv), .resync(rs),
        .locked(lk[0]), .err(er[0]), .wrap(wr[0]), .err_count(ec[0]), .wrap_count(wc[0])
    );

    ripple_monitor #(.WIDTH(4), .LOCK_LEN(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .Reset(rst), .count_in(ci), .count_valid(cv), .resync(rs),
        .locked(lk[1]), .err(er[1]), .wrap(wr[1]), .err_count(ec[1]), .wrap_count(wc[1])
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lock_len(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    task automatic model_step(input int k, input bit r, input bit v, input bit s, input int val);
        bit was_locked;
        m_err[k]  = 0;
        m_wrap[k] = 0;
        if (r) begin
            m_streak[k] = 0;
            m_last[k]   = 0;
            m_ec[k]     = 0;
            m_wc[k]     = 0;
        end else if (s) begin
            m_streak[k] = 0;
        end else if (v) begin
            was_locked = (m_streak[k] >= lock_len(k) + 1);
            if (m_streak[k] == 0) begin
                m_streak[k] = 1;
            end else if (val == (m_last[k] + 1) % 16) begin
                if (was_locked && m_last[k] == 15) begin
                    m_wrap[k] = 1;
                    if (m_wc[k] < 255) m_wc[k]++;
                end
                m_streak[k]++;
            end else begin
                if (was_locked) begin
                    m_err[k] = 1;
                    if (m_ec[k] < 255) m_ec[k]++;
                end
                m_streak[k] = 1;
            end
            m_last[k] = val;
        end
    endtask

    task automatic step(input bit r, input bit v, input bit s, input int val);
        @(negedge clk);
        rst = r;
        cv  = v;
        rs  = s;
        ci  = val[3:0];
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k, r, v, s, val);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("locked%0d", k), int'(lk[k]), int'(m_streak[k] >= lock_len(k) + 1));
            check($sformatf("err%0d", k), int'(er[k]), m_err[k]);
            check($sformatf("wrap%0d", k), int'(wr[k]), m_wrap[k]);
            check($sformatf("err_count%0d", k), int'(ec[k]), m_ec[k]);
            check($sformatf("wrap_count%0d", k), int'(wc[k]), m_wc[k]);
        end
    endtask

    initial begin
        int last;
        int val;
        rst = 1'b1; cv = 1'b0; rs = 1'b0; ci = '0;
        for (int k = 0; k < 2; k++) begin
            m_streak[k] = 0; m_last[k] = 0; m_ec[k] = 0; m_wc[k] = 0;
            m_err[k] = 0; m_wrap[k] = 0;
        end

        step(1, 1, 1, 7);
        step(1, 0, 0, 0);

        // acquisition: lock exactly on sample 4
        for (int i = 0; i <= 3; i++) step(0, 1, 0, i);
        check("not_locked_before_4", int'(lk[0]), 0);
        step(0, 1, 0, 4);
        check("locked_after_4", int'(lk[0]), 1);

        // wrap through 15 -> 0
        for (int i = 5; i <= 15; i++) step(0, 1, 0, i);
        step(0, 1, 0, 0);
        check("wrap_pulse", int'(wr[0]), 1);
        step(0, 1, 0, 1);
        check("wrap_count_1", int'(wc[0]), 1);

        // break at 6 -> 9, relock after 13
        for (int i = 2; i <= 6; i++) step(0, 1, 0, i);
        step(0, 1, 0, 9);
        check("err_pulse", int'(er[0]), 1);
        check("lock_lost", int'(lk[0]), 0);
        for (int i = 10; i <= 13; i++) step(0, 1, 0, i);
        check("relocked_13", int'(lk[0]), 1);

        // resync while locked at 12
        step(0, 1, 0, 14);
        step(0, 1, 0, 15);
        for (int i = 0; i <= 12; i++) step(0, 1, 0, i);
        step(0, 1, 1, 0);
        for (int i = 0; i <= 4; i++) step(0, 1, 0, i);
        check("resync_no_err", int'(ec[0]), 1);
        check("resync_relock", int'(lk[0]), 1);

        // idle gap keeps lock
        for (int i = 0; i < 20; i++) step(0, 0, 0, $urandom_range(0, 15));
        step(0, 1, 0, 5);
        step(0, 1, 0, 6);
        check("gap_locked", int'(lk[0]), 1);

        // randomized stream, mostly well-behaved
        last = 6;
        for (int i = 0; i < 3000; i++) begin
            bit r, v, s;
            r = ($urandom_range(0, 199) == 0);
            s = ($urandom_range(0, 39) == 0);
            v = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 19) < 17) val = (last + 1) % 16;
            else val = $urandom_range(0, 15);
            step(r, v, s, val);
            if (v) last = val;
        end

        // saturation of err_count on the LOCK_LEN=1 instance
        step(1, 0, 0, 0);
        last = 0;
        step(0, 1, 0, last);
        for (int i = 0; i < 270; i++) begin
            last = (last + 1) % 16;
            step(0, 1, 0, last);
            last = (last + 3) % 16;
            step(0, 1, 0, last);
        end
        check("err_count_saturated", int'(ec[1]), 255);
        step(1, 1, 0, (last + 1) % 16);
        check("reset_clears_err_count", int'(ec[1]), 0);
        check("reset_clears_locked", int'(lk[1]), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ripple_monitor.md
# ripple_monitor

Sequence monitor that sits on the output of the 4-bit ripple counter and checks, one sample per clock, that the value advances by exactly +1 modulo 2^WIDTH. It acquires lock after a run of good increments, then flags every break in sequence, counts errors and wrap-arounds, and tolerates a legitimate counter reset through a resync input. It is the consuming end of the counter's output bus and is used both in-system and in benches as a self-checking observer.

## Interface
- WIDTH, 4, width of the observed count
- LOCK_LEN, 4, consecutive correct increments needed to declare lock (range 1..15)
- CNT_W, 8, width of the error and wrap counters
- clk  input  1  rising-edge clock, shared with the counter
- Reset  input  1  synchronous, active-high reset; sampled on rising clk
- count_in  input  WIDTH  observed counter value
- count_valid  input  1  count_in is a valid sample this cycle
- resync  input  1  source was legitimately reset; drop lock without flagging an error
- locked  output  1  sequence acquired and currently tracking
- err  output  1  one-cycle pulse: sequence break while locked
- wrap  output  1  one-cycle pulse: correct max-to-0 transition while locked
- err_count  output  CNT_W  saturating count of err pulses
- wrap_count  output  CNT_W  saturating count of wrap pulses

## Operation
- Internal: state {IDLE, ACQ, LOCK}, ref register (WIDTH), run counter (4 bits).
- Expected value = ref + 1, truncated to WIDTH bits (so ref = 2^WIDTH-1 expects 0).
- IDLE: on count_valid, ref <= count_in, run <= 0, go ACQ.
- ACQ: on count_valid, ref <= count_in always. If count_in == expected: run <= run+1; if run+1 == LOCK_LEN go LOCK. Else run <= 0, stay ACQ. No err in ACQ.
- LOCK: on count_valid, ref <= count_in. Match: stay; if ref was 2^WIDTH-1, pulse wrap, wrap_count +1. Mismatch: pulse err, err_count +1, run <= 0, go ACQ.
- count_valid low: no state, ref, run or counter change; err/wrap low.
- resync high (any state): go IDLE, run <= 0, no err; err_count/wrap_count kept. resync beats count_valid in the same cycle.
- Counters saturate at 2^CNT_W-1; never wrap.
- locked = (state == LOCK), registered.

## Timing
- All outputs registered; sample at edge N produces err/wrap/locked/counter update visible after edge N.
- err and wrap are exactly one cycle wide per offending/wrapping sample; back-to-back samples may produce back-to-back pulses.
- Lock latency: from first valid sample, LOCK_LEN+1 valid correct samples; locked high after the edge capturing the last.
- Loss of lock: locked falls after the same edge that raises err.
- Reset: state IDLE, ref 0, run 0, locked 0, err 0, wrap 0, err_count 0, wrap_count 0. Reset overrides resync and count_valid; reset mid-run discards lock and counters.
- err and wrap never asserted together.

## Test plan
- Reset, then count_in 0,1,2,3,4 valid every cycle (LOCK_LEN=4) -> locked rises after the sample 4 edge; err_count 0.
- Locked, feed 14,15,0,1 -> single wrap pulse on sample 0, wrap_count 1, no err.
- Locked at 6, feed 9 -> err pulse one cycle, err_count 1, locked falls same edge; then 10,11,12,13 -> relock after 13.
- Locked at 12, assert resync with count_in 0, then 0,1,2,3,4 -> no err, err_count unchanged, locked again after 4.
- Hold count_valid low 20 cycles mid-lock, then resume at next value -> locked stays high, no pulses.
- Force 260 mismatches (alternating values, LOCK_LEN=1) -> err_count saturates at 255; Reset mid-stream clears all outputs to 0 next cycle.
